// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle of the sequencer's handshake and enable signals.
//   master : the sequencer (mc_ctrl) -- takes ins/zero/iack/dack, drives
//            the PC/IR/EX/memory/register-file enables, state and retcnt.
//   slave  : the datapath/memory side -- the mirror image.
// Parameter CNT_W sets the width of the retired-instruction counter.
// Macro MC_CTRL_TRAP_EN adds the exc (illegal-instruction trap) signal.
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0]      ins;
  logic             zero;
  logic             iack;
  logic             dack;
  logic             ird;
  logic             irwr;
  logic             pcwr;
  logic             pcsel;
  logic             exen;
  logic             drd;
  logic             dwr;
  logic             regwr;
  logic [1:0]       wbsel;
  logic [2:0]       state;
  logic [CNT_W-1:0] retcnt;
`ifdef MC_CTRL_TRAP_EN
  logic             exc;

  modport master (
    input  ins, zero, iack, dack,
    output ird, irwr, pcwr, pcsel, exen, drd, dwr, regwr, wbsel, state, retcnt, exc
  );
  modport slave (
    output ins, zero, iack, dack,
    input  ird, irwr, pcwr, pcsel, exen, drd, dwr, regwr, wbsel, state, retcnt, exc
  );
`else
  modport master (
    input  ins, zero, iack, dack,
    output ird, irwr, pcwr, pcsel, exen, drd, dwr, regwr, wbsel, state, retcnt
  );
  modport slave (
    output ins, zero, iack, dack,
    input  ird, irwr, pcwr, pcsel, exen, drd, dwr, regwr, wbsel, state, retcnt
  );
`endif
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS sequencer FETCH -> DECODE -> EXEC -> MEM -> WB.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mc_ctrl_if.master -- ins/zero/iack/dack in; ird, irwr, pcwr,
//          pcsel, exen, drd, dwr, regwr, wbsel, state, retcnt (and exc) out
// Parameter CNT_W: retired-instruction counter width (wraps modulo 2^CNT_W).
// Macro MC_CTRL_TRAP_EN: illegal instructions trap in TRAP with exc=1 until
// reset; without it they run as a NOP and retire.
// irwr/pcwr/pcsel depend on iack and zero within the cycle, so they are
// decoded combinationally from the state register; all other outputs are
// registered and loaded with the value for the state being entered.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU = 4'd0,
    CL_JR  = 4'd1,
    CL_LW  = 4'd2,
    CL_SW  = 4'd3,
    CL_BEQ = 4'd4,
    CL_BNE = 4'd5,
    CL_J   = 4'd6,
    CL_JAL = 4'd7,
    CL_ILL = 4'd8
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Instruction class from opcode and funct fields.
  function automatic cls_t decode_cls(input logic [5:0] op, input logic [5:0] funct);
    cls_t c;
    case (op)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: c = CL_ALU;
          6'h08:        c = CL_JR;
          default:      c = CL_ILL;
        endcase
      end
      6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: c = CL_ALU;
      6'h23:   c = CL_LW;
      6'h2B:   c = CL_SW;
      6'h04:   c = CL_BEQ;
      6'h05:   c = CL_BNE;
      6'h02:   c = CL_J;
      6'h03:   c = CL_JAL;
      default: c = CL_ILL;
    endcase
    return c;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] retcnt_r;
  logic             ird_r;
  logic             exen_r;
  logic             drd_r;
  logic             dwr_r;
  logic             regwr_r;
  logic [1:0]       wbsel_r;
`ifdef MC_CTRL_TRAP_EN
  logic             exc_r;
`endif

  cls_t cls_s;
  logic take_s;
  logic irwr_s;
  logic pcwr_s;
  logic pcsel_s;

  assign cls_s = decode_cls(bus.ins[31:26], bus.ins[5:0]);

  // Mealy enables: IR/PC load on iack in FETCH, PC redirect in EXEC.
  // Gated by rst so nothing writes while reset is held.
  always_comb begin
    take_s  = 1'b0;
    irwr_s  = 1'b0;
    pcwr_s  = 1'b0;
    pcsel_s = 1'b0;
    case (cls_s)
      CL_BEQ:             take_s = bus.zero;
      CL_BNE:             take_s = ~bus.zero;
      CL_J, CL_JAL, CL_JR: take_s = 1'b1;
      default:            take_s = 1'b0;
    endcase
    if (rst) begin
      irwr_s  = 1'b0;
      pcwr_s  = 1'b0;
      pcsel_s = 1'b0;
    end else if (state_r == ST_FETCH) begin
      irwr_s  = bus.iack;
      pcwr_s  = bus.iack;
    end else if (state_r == ST_EXEC) begin
      pcwr_s  = take_s;
      pcsel_s = take_s;
    end else begin
      irwr_s  = 1'b0;
      pcwr_s  = 1'b0;
      pcsel_s = 1'b0;
    end
  end

  // Sequencer FSM; registered outputs take the value of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_FETCH;
      retcnt_r <= {CNT_W{1'b0}};
      ird_r    <= 1'b1;
      exen_r   <= 1'b0;
      drd_r    <= 1'b0;
      dwr_r    <= 1'b0;
      regwr_r  <= 1'b0;
      wbsel_r  <= 2'b00;
`ifdef MC_CTRL_TRAP_EN
      exc_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (bus.iack) begin
            state_r <= ST_DECODE;
            ird_r   <= 1'b0;
          end
        end
        ST_DECODE: begin
`ifdef MC_CTRL_TRAP_EN
          if (cls_s == CL_ILL) begin
            state_r <= ST_TRAP;
            exc_r   <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
            exen_r  <= 1'b1;
          end
`else
          state_r <= ST_EXEC;
          exen_r  <= 1'b1;
`endif
        end
        ST_EXEC: begin
          exen_r <= 1'b0;
          case (cls_s)
            CL_LW: begin
              state_r <= ST_MEM;
              drd_r   <= 1'b1;
            end
            CL_SW: begin
              state_r <= ST_MEM;
              dwr_r   <= 1'b1;
            end
            CL_ALU, CL_JAL: begin
              state_r <= ST_WB;
              regwr_r <= 1'b1;
              wbsel_r <= (cls_s == CL_JAL) ? 2'b10 : 2'b00;
            end
            default: begin
              // branches, jumps and (untrapped) illegal ops retire here
              state_r  <= ST_FETCH;
              ird_r    <= 1'b1;
              retcnt_r <= retcnt_r + CNT_ONE;
            end
          endcase
        end
        ST_MEM: begin
          if (bus.dack) begin
            drd_r <= 1'b0;
            dwr_r <= 1'b0;
            if (cls_s == CL_LW) begin
              state_r <= ST_WB;
              regwr_r <= 1'b1;
              wbsel_r <= 2'b01;
            end else begin
              state_r  <= ST_FETCH;
              ird_r    <= 1'b1;
              retcnt_r <= retcnt_r + CNT_ONE;
            end
          end
        end
        ST_WB: begin
          state_r  <= ST_FETCH;
          regwr_r  <= 1'b0;
          wbsel_r  <= 2'b00;
          ird_r    <= 1'b1;
          retcnt_r <= retcnt_r + CNT_ONE;
        end
`ifdef MC_CTRL_TRAP_EN
        ST_TRAP: begin
          state_r <= ST_TRAP;
        end
`endif
        default: begin
          // unreachable encodings recover to FETCH with enables cleared
          state_r <= ST_FETCH;
          ird_r   <= 1'b1;
          exen_r  <= 1'b0;
          drd_r   <= 1'b0;
          dwr_r   <= 1'b0;
          regwr_r <= 1'b0;
          wbsel_r <= 2'b00;
        end
      endcase
    end
  end

  assign bus.state  = state_r;
  assign bus.retcnt = retcnt_r;
  assign bus.ird    = ird_r;
  assign bus.irwr   = irwr_s;
  assign bus.pcwr   = pcwr_s;
  assign bus.pcsel  = pcsel_s;
  assign bus.exen   = exen_r;
  assign bus.drd    = drd_r;
  assign bus.dwr    = dwr_r;
  assign bus.regwr  = regwr_r;
  assign bus.wbsel  = wbsel_r;
`ifdef MC_CTRL_TRAP_EN
  assign bus.exc    = exc_r;
`endif

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the MIPS core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the enables of the PC, IR, EX stage, data memory and register file. It waits on instruction and data memory acknowledges and counts retired instructions. It sits beside the EX stage and consumes the latched instruction word and the EX zero flag.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- Ins  in  32  latched instruction register contents, stable from the cycle after IRWr until the next FETCH
- Zero  in  1  EX result equals zero, valid during EXEC
- IAck  in  1  instruction memory read complete
- DAck  in  1  data memory access complete
- IRd  out  1  instruction memory read request
- IRWr  out  1  latch instruction register
- PCWr  out  1  PC write enable
- PCSel  out  1  PC source: 0 = nextPC, 1 = newPC from EX
- ExEn  out  1  EX stage operand/result capture enable
- DRd, DWr  out  1 each  data memory read / write request
- RegWr  out  1  register file write enable
- WbSel  out  2  write-back source: 00 = Result, 01 = memory data, 10 = nextPC (link)
- State  out  3  current state, for debug
- RetCnt  out  CNT_W  retired-instruction count
- Exc  out  1  illegal-instruction trap flag; present only with MC_CTRL_TRAP_EN

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Instruction classes, decoded from Ins[31:26] and funct Ins[5:0]:
  - ALU: op 00 with funct 00, 02, 03, 20–27, 2A or 2B; op 08 and 0A–0F.
  - JR: op 00 with funct 08.
  - LW: op 23. SW: op 2B.
  - BR: op 04 (BEQ), op 05 (BNE).
  - J: op 02. JAL: op 03.
  - Anything else is illegal.
- FETCH: IRd=1. When IAck=1, assert IRWr and PCWr (PCSel=0) in the same cycle; these are Mealy outputs on IAck. Next state is DECODE. Otherwise stay in FETCH.
- DECODE: one cycle with no enables. Next state is EXEC, or TRAP for an illegal instruction with the macro defined.
- EXEC: ExEn=1.
  - BEQ: PCWr=PCSel=1 if Zero=1.
  - BNE: PCWr=PCSel=1 if Zero=0.
  - J, JAL, JR: PCWr=PCSel=1 unconditionally.
  - Next state: LW/SW → MEM; ALU/JAL → WB; BR/J/JR/illegal → FETCH (retire).
- MEM: DRd=1 for LW, DWr=1 for SW, held until DAck. On DAck, LW → WB and SW → FETCH (retire).
- WB: RegWr=1. WbSel is 01 for LW, 10 for JAL, 00 otherwise. Next state is FETCH (retire).
- Retire: RetCnt increments by 1 on the final-state exit of each instruction. It wraps modulo 2^CNT_W.
- Idle outputs: WbSel=00 and PCSel=0 in every state that does not drive them.

## Timing
- Reset (asynchronous, immediate):
  - State=FETCH, RetCnt=0, Exc=0.
  - Outputs during reset: IRd=1, all other enables 0, WbSel=00.
- Reset mid-operation: a reset in any state aborts the instruction immediately. DRd/DWr/RegWr drop in the same cycle and nothing retires.
- Latency with zero-wait memory (IAck/DAck high on the first request cycle):
  - ALU, JAL: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BR, J, JR: 3 cycles.
- Each extra wait cycle adds exactly 1 cycle.
- Ignored acknowledges: IAck outside FETCH and DAck outside MEM have no effect.
- Write enables: at most one of PCWr/RegWr/DWr is asserted per cycle, except FETCH, where IRWr and PCWr assert together.
- Ins may change freely during FETCH until IRWr.

## Configuration
- MC_CTRL_TRAP_EN defined:
  - An illegal instruction goes DECODE → TRAP.
  - TRAP asserts Exc=1 and holds all enables at 0. It is left only by RST, and the instruction does not retire.
- MC_CTRL_TRAP_EN undefined:
  - TRAP is unreachable and the Exc port is absent.
  - An illegal instruction executes as a NOP: FETCH→DECODE→EXEC→FETCH, no PCWr/RegWr/DWr, and RetCnt increments.

## Test plan
- ADD (Ins=0x00000020), IAck=1: State sequence 0,1,2,4,0. RegWr=1 with WbSel=00 only in cycle 4. RetCnt 0→1.
- LW (0x8C000000), DAck delayed 2 cycles: DRd high for 3 cycles, then WB with WbSel=01. Total 7 cycles.
- BEQ (0x10000003):
  - Zero=1: PCWr=PCSel=1 in EXEC.
  - Zero=0: no PCWr in EXEC.
  - Both cases return to FETCH after 3 cycles.
- Illegal 0xFC000000:
  - With macro: State=5, Exc=1 and held for 10 cycles, RetCnt unchanged.
  - Without macro: sequence 0,1,2,0 with no writes, RetCnt+1.
- SW (0xAC000000) with RST asserted during MEM: DWr drops the same cycle, State=0, RetCnt=0, IRd=1.
- CNT_W=4, 17 back-to-back ALU instructions: RetCnt reads 0 after the 16th and 1 after the 17th.
